// File: rtl/pipeline_mul_arbiter.sv
// Two-requester front end sharing one iterative shift-and-add multiplier.
// Requests are arbitrated round-robin in IDLE; the product is held in DONE until it is taken.
module pipeline_mul_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high.
  // reqN_ready depends only on state, arbitration and the valids, never on operand data.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;

  logic grant;
  logic idle;
  logic hs;
  logic x_le1, y_le1;

  assign idle  = (state_q == S_IDLE);
  assign grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  assign req0_ready = idle && !rst && req0_valid && !grant;
  assign req1_ready = idle && !rst && req1_valid && grant;
  assign hs         = req0_ready || req1_ready;

  assign x_le1 = ((x_q >> 1) == '0);
  assign y_le1 = ((y_q >> 1) == '0);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    res_d        = res_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          x_d          = grant ? req1_a : req0_a;
          y_d          = grant ? req1_b : req0_b;
          res_d        = '0;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // Finishing steps also latch the response so rsp_data only moves on entry to DONE.
        if (y_le1) begin
          res_d      = res_q + (x_q & {WIDTH{y_q[0]}});
          rsp_data_d = res_d;
          rsp_id_d   = owner_q;
          state_d    = S_DONE;
        end else if (x_le1) begin
          res_d      = res_q + (y_q & {WIDTH{x_q[0]}});
          rsp_data_d = res_d;
          rsp_id_d   = owner_q;
          state_d    = S_DONE;
        end else begin
          res_d = res_q + (y_q & {WIDTH{x_q[0]}});
          x_d   = x_q >> 1;
          y_d   = y_q << 1;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      res_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      res_q        <= res_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = !idle;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_mul_arbiter.sv
// Directed plus randomized bench for pipeline_mul_arbiter; a reference model derives
// products and run lengths arithmetically from the operands.
module tb_pipeline_mul_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_id;
  logic         rsp_ready;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  pipeline_mul_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the product modulo 2^W, and the run length as the first step k at
  // which either the right-shifted multiplier or the left-shifted multiplicand is 0 or 1.
  function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[W-1:0];
  endfunction

  function automatic int model_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] xk, yk;
    for (int k = 0; k < 2 * W; k++) begin
      xk = a >> k;
      yk = b << k;
      if (xk <= 1 || yk <= 1) return k + 1;
    end
    return 999;
  endfunction

  // driver tasks (called at a negedge)
  task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // After a handshake edge: count RUN cycles, check the response, apply hold cycles of
  // backpressure, then take it.
  task automatic wait_rsp(input bit exp_id, input int exp_cyc, input int hold);
    int cnt;
    logic [W-1:0] exp_data;
    logic [W-1:0] d0;
    logic         i0;
    cnt = 0;
    while (!rsp_valid && cnt <= 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("run_cycles", 64'(cnt), 64'(exp_cyc));
    chk("run_le_width", 64'(cnt <= W), 64'd1);
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_data", 64'(rsp_data), 64'(exp_data));
    chk("rsp_id", 64'(rsp_id), 64'(exp_id));
    d0 = rsp_data;
    i0 = rsp_id;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", 64'(rsp_data), 64'(d0));
      chk("hold_id", 64'(rsp_id), 64'(i0));
      chk("hold_readies", 64'({req0_ready, req1_ready}), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("done_hs_readies", 64'({req0_ready, req1_ready}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("after_rsp_busy", 64'(busy), 64'd0);
    chk("after_rsp_data", 64'(rsp_data), 64'(d0));
  endtask

  task automatic single_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
    drive_req(id, a, b);
    #1;
    chk("grant", 64'({req1_ready, req0_ready}), id ? 64'd2 : 64'd1);
    exp_q.push_back(model_prod(a, b));
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    req0_a = $urandom; req1_a = $urandom;
    wait_rsp(id, model_cycles(a, b), hold);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit id;
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_readies", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    clear_reqs();
    rst = 1'b0;
    @(negedge clk);

    // contention after reset: req0 first, then req1, then req0 again
    drive_req(0, 32'd3, 32'd5);
    drive_req(1, 32'd2, 32'd9);
    #1;
    chk("cont_grant0", 64'({req1_ready, req0_ready}), 64'd1);
    exp_q.push_back(32'd15);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(0, model_cycles(3, 5), 2);
    chk("cont_grant1", 64'({req1_ready, req0_ready}), 64'd2);
    exp_q.push_back(32'd18);
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    wait_rsp(1, model_cycles(2, 9), 0);
    drive_req(0, 32'd4, 32'd4);
    drive_req(1, 32'd5, 32'd5);
    #1;
    chk("cont_again_grant0", 64'({req1_ready, req0_ready}), 64'd1);
    exp_q.push_back(32'd16);
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    wait_rsp(0, model_cycles(4, 4), 0);

    // single multiply, backpressure, trivial operands, wrap
    single_op(0, 32'd6, 32'd7, 0);
    single_op(1, 32'd11, 32'd13, 5);
    single_op(0, 32'd0, 32'h1234, 0);
    single_op(1, 32'd1, 32'hABCD, 1);
    single_op(0, 32'h55, 32'd1, 0);
    single_op(1, 32'h8000_0000, 32'd2, 0);
    single_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // reset mid-RUN abandons the operation
    drive_req(0, 32'h1234, 32'h5678);
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    repeat (3) @(negedge clk);
    chk("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_valid", 64'(rsp_valid), 64'd0);
    chk("midrun_rst_readies", 64'({req0_ready, req1_ready}), 64'd0);
    clear_reqs();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("midrun_no_rsp", 64'(seen), 64'd0);
    end
    drive_req(0, 32'h1234, 32'h5678);
    drive_req(1, 32'd7, 32'd7);
    #1;
    chk("post_rst_grant0", 64'({req1_ready, req0_ready}), 64'd1);
    exp_q.push_back(model_prod(32'h1234, 32'h5678));
    @(posedge clk);
    @(negedge clk);
    clear_reqs();
    wait_rsp(0, model_cycles(32'h1234, 32'h5678), 0);

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      id = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      single_op(id, a, b, $urandom_range(0, 3));
    end

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_mul_arbiter.md
PIPELINE_MUL_ARBITER -- requirements
Module: pipeline_mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready: same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  product available.
REQ-009 rsp_data  output  WIDTH  product, modulo 2^WIDTH.
REQ-010 rsp_id  output  1  requester that owns rsp_data.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block has three states: IDLE, RUN and DONE. It holds one shared iterative multiplier with registers x, y, res (WIDTH each), an owner bit, and a last_grant bit.
REQ-014 Arbitration in IDLE:
- A single valid requester is granted.
- If both requesters are valid, the one not equal to last_grant is granted.
REQ-015 reqN_ready is combinational: high only in IDLE, for the granted requester, and never high for both requesters.
REQ-016 On a handshake (valid and ready high):
- x <= a, y <= b, res <= 0.
- owner <= N, last_grant <= N.
- State goes to RUN.
REQ-017 Each RUN cycle evaluates the following in priority order:
- (a) If y==0 or y==1: res <= res + (x AND replicated y[0]); go to DONE.
- (b) Else if x==0 or x==1: res <= res + (y AND replicated x[0]); go to DONE.
- (c) Else: res <= res + (y AND replicated x[0]); x <= x>>1; y <= y<<1; stay in RUN.
REQ-018 All additions and shifts wrap modulo 2^WIDTH. Bits shifted out are discarded.
REQ-019 RUN lasts at least 1 cycle and at most WIDTH cycles for any operands.
REQ-020 In DONE:
- rsp_valid=1, rsp_data=res, rsp_id=owner; these outputs stay stable until rsp_ready is seen high.
- The handshake cycle returns the state to IDLE.
REQ-021 When rsp_valid is low, rsp_data and rsp_id hold their last values.
REQ-022 No new request is granted in the same cycle as a DONE handshake; a new grant occurs no earlier than the following IDLE cycle.
REQ-023 Requester valid/data changes outside IDLE have no effect; operands are sampled only at the handshake.
REQ-024 rsp_ready asserted while rsp_valid is low is ignored.

Reset
REQ-025 While rst is high at a clock edge:
- state <= IDLE; x, y, res <= 0; owner <= 0; last_grant <= 1.
- rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
REQ-026 In the cycle rst is high, req0_ready and req1_ready are 0.
REQ-027 Reset during RUN or DONE abandons the operation; no response for it is ever issued.
REQ-028 After reset deasserts, the first simultaneous request pair grants requester 0.

Verification
REQ-029 The bench shall cover each of the following scenarios:
- Single multiply: req0 6*7 handshake at cycle T -> RUN for 3 cycles; rsp_valid=1, rsp_data=42, rsp_id=0 at T+4.
- Contention: req0 and req1 valid together after reset, req0 3*5, req1 2*9 -> req0 granted first, rsp 15/id0; then req1 granted, rsp 18/id1; a subsequent contention grants req0 again.
- Backpressure: rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable; both readies stay 0; a single response is delivered on release.
- Early exit and trivial operands: 0*0x1234 -> 0, 1*0xABCD -> 0xABCD, 0x55*1 -> 0x55; each completes after exactly 1 RUN cycle.
- Wrap: 0x80000000*2 -> rsp_data=0x00000000; 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; RUN never exceeds 32 cycles.
- Reset mid-RUN: rst pulsed during a 0x1234*0x5678 operation -> no rsp_valid; busy=0; a fresh request then completes correctly.
